hazard_detection_unit: RTL and testbench
========================================

Name: hazard_detection_unit

Overview:
- Producer side of the pipeline flush/stall interface. Generates the load-use hazard signal consumed by the flush unit, plus the branch/jump signal gated against memory stalls.
- Also generates a global freeze while the data memory is busy, and a PC hold.
- Sits between the ID/EX/MEM pipeline-register outputs and the flush unit / PC logic.
- A small FSM guarantees exactly one bubble per load-use event and tracks multi-cycle memory waits with a timeout watchdog.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- TIMEOUT_CYCLES, 256, consecutive DMEM_BUSY cycles in MEM_WAIT before MEM_TIMEOUT is flagged. Legal range is 2 to 65535.
- CNT_W, 32, width of the optional performance counters.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ID_RS1_ADDR  in  REG_ADDR_W  rs1 of the instruction in ID.
- ID_RS2_ADDR  in  REG_ADDR_W  rs2 of the instruction in ID.
- ID_RS1_USED  in  1  ID instruction reads rs1.
- ID_RS2_USED  in  1  ID instruction reads rs2.
- EX_RD_ADDR  in  REG_ADDR_W  destination of the instruction in EX.
- EX_MEM_READ  in  1  instruction in EX is a load.
- MEM_ACCESS  in  1  instruction in MEM is a load or store.
- DMEM_BUSY  in  1  data memory not ready this cycle.
- BJ_SIG  in  1  branch/jump taken, resolved in EX.
- BJ_SIG_OUT  out  1  gated branch/jump signal to the flush unit.
- LU_HAZ_SIG  out  1  load-use hazard signal to the flush unit.
- PC_HOLD  out  1  PC must not update.
- PIPE_STALL  out  1  freeze all pipeline registers.
- MEM_TIMEOUT  out  1  sticky watchdog flag.
- LU_STALL_CNT  out  CNT_W  optional performance counter.
- MEM_STALL_CNT  out  CNT_W  optional performance counter.

Behaviour:
- Reset:
  - RESET asserted (asynchronous): state=RUN, wait_cnt=0, MEM_TIMEOUT=0, counters=0.
  - Combinational outputs BJ_SIG_OUT, LU_HAZ_SIG, PC_HOLD and PIPE_STALL are forced to 0 while RESET is high.
  - Reset mid-stall aborts the wait immediately; no state is retained.
- Definitions:
  - mstall = MEM_ACCESS && DMEM_BUSY.
  - haz = EX_MEM_READ && (EX_RD_ADDR != 0) && ((ID_RS1_USED && ID_RS1_ADDR==EX_RD_ADDR) || (ID_RS2_USED && ID_RS2_ADDR==EX_RD_ADDR)).
- Combinational outputs (zero latency, same cycle):
  - PIPE_STALL = mstall.
  - BJ_SIG_OUT = BJ_SIG && !mstall. A branch resolved during a freeze is held in EX and re-presented after the freeze.
  - LU_HAZ_SIG = haz && !BJ_SIG && !mstall && (state==RUN).
  - PC_HOLD = LU_HAZ_SIG || PIPE_STALL.
- Priority, highest first: memory stall, then branch/jump, then load-use.
- FSM states: RUN, LU_BUBBLE, MEM_WAIT.
  - RUN -> MEM_WAIT if mstall.
  - RUN -> LU_BUBBLE else if LU_HAZ_SIG.
  - RUN -> RUN otherwise.
  - LU_BUBBLE lasts one cycle. LU_HAZ_SIG is suppressed, so the hazard can never produce more than one bubble.
  - LU_BUBBLE -> MEM_WAIT if mstall, else RUN.
  - MEM_WAIT: wait_cnt increments each cycle with mstall and saturates at TIMEOUT_CYCLES.
  - MEM_WAIT -> RUN with wait_cnt=0 on the first cycle mstall=0.
  - A hazard present on MEM_WAIT exit is evaluated in the RUN cycle that follows.
- Watchdog:
  - The transition edge into MEM_WAIT counts as wait cycle 1.
  - MEM_TIMEOUT sets on the edge where wait_cnt reaches TIMEOUT_CYCLES-1 and mstall is still 1.
  - MEM_TIMEOUT is sticky until RESET. The stall itself continues; the watchdog only reports.
- Width rules:
  - wait_cnt width is $clog2(TIMEOUT_CYCLES+1).
  - Performance counters saturate at all-ones and never wrap.
- A register-0 destination never produces a hazard.
- Back-to-back load-use pairs each yield exactly one bubble.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined:
  - LU_STALL_CNT increments on each cycle with LU_HAZ_SIG=1.
  - MEM_STALL_CNT increments on each cycle with PIPE_STALL=1.
  - Both saturate.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package cpu_hazard_pkg holds:
  - FSM state encoding: HZ_RUN=2'd0, HZ_LU_BUBBLE=2'd1, HZ_MEM_WAIT=2'd2.
  - Default REG_ADDR_W and the TIMEOUT_CYCLES default.
- One natural sub-module, hazard_stall_watchdog: holds wait_cnt, the saturation logic and the MEM_TIMEOUT sticky flag.
- The FSM and the comparators stay in the top module.

Test Plan:
- Load-use hit:
  - Stimulus: EX_MEM_READ=1, EX_RD_ADDR=5, ID_RS1_USED=1, ID_RS1_ADDR=5, held 2 cycles.
  - Required: LU_HAZ_SIG=PC_HOLD=1 in cycle 1 only; 0 in cycle 2 (LU_BUBBLE); LU_STALL_CNT=1.
- Register-0 and unused-source cases:
  - Stimulus: EX_RD_ADDR=0 with matching rs1. Separately, rs2 matches with ID_RS2_USED=0.
  - Required: LU_HAZ_SIG=0 in both.
- Branch priority:
  - Stimulus: hazard and BJ_SIG=1 in the same cycle.
  - Required: LU_HAZ_SIG=0, BJ_SIG_OUT=1, state stays RUN.
- Memory freeze with a branch pending:
  - Stimulus: MEM_ACCESS=1, DMEM_BUSY=1 for 3 cycles, with BJ_SIG=1 and a hazard present.
  - Required: PIPE_STALL=PC_HOLD=1, BJ_SIG_OUT=0, LU_HAZ_SIG=0 for 3 cycles; BJ_SIG_OUT=1 on the first free cycle.
- Watchdog, with TIMEOUT_CYCLES=4:
  - Stimulus: DMEM_BUSY held 6 cycles.
  - Required: MEM_TIMEOUT rises after the 4th busy edge and stays 1 after busy drops; cleared only by RESET.
- Asynchronous reset mid-MEM_WAIT:
  - Stimulus: assert RESET between clock edges.
  - Required: all outputs 0 immediately, state RUN, wait_cnt=0.

Source files
------------

// File: rtl/cpu_hazard_pkg.sv
// cpu_hazard_pkg: shared FSM state encoding and parameter defaults for the hazard detection unit.
package cpu_hazard_pkg;
  typedef enum logic [1:0] {
    HZ_RUN       = 2'd0,
    HZ_LU_BUBBLE = 2'd1,
    HZ_MEM_WAIT  = 2'd2
  } hz_state_e;
  localparam int DEF_REG_ADDR_W     = 5;
  localparam int DEF_TIMEOUT_CYCLES = 256;
endpackage

// File: rtl/hazard_stall_watchdog.sv
// hazard_stall_watchdog: counts consecutive memory-stall cycles and raises a sticky timeout flag.
module hazard_stall_watchdog #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int WAIT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_wait,
  input  logic              mstall,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic              timeout
);
  // The edge entering the wait counts as cycle 1; the flag rises on the edge that completes cycle TIMEOUT_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else if (in_wait && mstall) begin
      wait_cnt <= (wait_cnt == WAIT_W'(TIMEOUT_CYCLES)) ? wait_cnt : wait_cnt + 1'b1;
      if (wait_cnt >= WAIT_W'(TIMEOUT_CYCLES - 1)) timeout <= 1'b1;
    end else begin
      wait_cnt <= mstall ? WAIT_W'(1) : '0;
    end
  end
endmodule

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: load-use, branch gating and memory-freeze control for the pipeline.
// Define HAZ_PERF_CNT_EN to build the saturating stall performance counters.
module hazard_detection_unit
  import cpu_hazard_pkg::*;
#(
  parameter int REG_ADDR_W     = DEF_REG_ADDR_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [REG_ADDR_W-1:0] ID_RS1_ADDR,
  input  logic [REG_ADDR_W-1:0] ID_RS2_ADDR,
  input  logic                  ID_RS1_USED,
  input  logic                  ID_RS2_USED,
  input  logic [REG_ADDR_W-1:0] EX_RD_ADDR,
  input  logic                  EX_MEM_READ,
  input  logic                  MEM_ACCESS,
  input  logic                  DMEM_BUSY,
  input  logic                  BJ_SIG,
  output logic                  BJ_SIG_OUT,
  output logic                  LU_HAZ_SIG,
  output logic                  PC_HOLD,
  output logic                  PIPE_STALL,
  output logic                  MEM_TIMEOUT,
  output logic [CNT_W-1:0]      LU_STALL_CNT,
  output logic [CNT_W-1:0]      MEM_STALL_CNT
);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  hz_state_e         state, state_n;
  logic              mstall, haz;
  logic [WAIT_W-1:0] wait_cnt;
  assign mstall = MEM_ACCESS && DMEM_BUSY;
  assign haz = EX_MEM_READ && (EX_RD_ADDR != '0) &&
               ((ID_RS1_USED && ID_RS1_ADDR == EX_RD_ADDR) || (ID_RS2_USED && ID_RS2_ADDR == EX_RD_ADDR));
  // Priority: memory freeze over branch/jump over load-use; all forced low during reset.
  assign PIPE_STALL = !RESET && mstall;
  assign BJ_SIG_OUT = !RESET && BJ_SIG && !mstall;
  assign LU_HAZ_SIG = !RESET && haz && !BJ_SIG && !mstall && (state == HZ_RUN);
  assign PC_HOLD    = LU_HAZ_SIG || PIPE_STALL;
  always_comb begin
    state_n = mstall ? HZ_MEM_WAIT : LU_HAZ_SIG ? HZ_LU_BUBBLE : HZ_RUN;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= HZ_RUN;
    else       state <= state_n;
  end
  hazard_stall_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .WAIT_W        (WAIT_W)
  ) u_watchdog (
    .clk     (CLK),
    .rst     (RESET),
    .in_wait (state == HZ_MEM_WAIT),
    .mstall  (mstall),
    .wait_cnt(wait_cnt),
    .timeout (MEM_TIMEOUT)
  );
`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      LU_STALL_CNT  <= '0;
      MEM_STALL_CNT <= '0;
    end else begin
      if (LU_HAZ_SIG && !(&LU_STALL_CNT)) LU_STALL_CNT <= LU_STALL_CNT + CNT_W'(1);
      if (PIPE_STALL && !(&MEM_STALL_CNT)) MEM_STALL_CNT <= MEM_STALL_CNT + CNT_W'(1);
    end
  end
`else
  assign LU_STALL_CNT  = '0;
  assign MEM_STALL_CNT = '0;
`endif
endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb_hazard_detection_unit: directed scoreboard bench for hazard_detection_unit with a 4-cycle watchdog.
module tb_hazard_detection_unit;
  import cpu_hazard_pkg::*;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic        CLK = 1'b0, RESET = 1'b1;
  logic [4:0]  ID_RS1_ADDR, ID_RS2_ADDR, EX_RD_ADDR;
  logic        ID_RS1_USED, ID_RS2_USED, EX_MEM_READ, MEM_ACCESS, DMEM_BUSY, BJ_SIG;
  logic        BJ_SIG_OUT, LU_HAZ_SIG, PC_HOLD, PIPE_STALL, MEM_TIMEOUT;
  logic [31:0] LU_STALL_CNT, MEM_STALL_CNT;
  int          compared = 0, mismatched = 0;
  typedef struct {
    string      tag;
    logic [4:0] exp;
  } sb_item_t;
  sb_item_t sb[$];

  hazard_detection_unit #(.REG_ADDR_W(5), .TIMEOUT_CYCLES(4), .CNT_W(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR),
    .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED),
    .EX_RD_ADDR(EX_RD_ADDR), .EX_MEM_READ(EX_MEM_READ),
    .MEM_ACCESS(MEM_ACCESS), .DMEM_BUSY(DMEM_BUSY), .BJ_SIG(BJ_SIG),
    .BJ_SIG_OUT(BJ_SIG_OUT), .LU_HAZ_SIG(LU_HAZ_SIG), .PC_HOLD(PC_HOLD),
    .PIPE_STALL(PIPE_STALL), .MEM_TIMEOUT(MEM_TIMEOUT),
    .LU_STALL_CNT(LU_STALL_CNT), .MEM_STALL_CNT(MEM_STALL_CNT)
  );

  always #5 CLK = ~CLK;

  // Output bundle: {BJ_SIG_OUT, LU_HAZ_SIG, PC_HOLD, PIPE_STALL, MEM_TIMEOUT}
  wire logic [4:0] obs = {BJ_SIG_OUT, LU_HAZ_SIG, PC_HOLD, PIPE_STALL, MEM_TIMEOUT};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  task automatic drv(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                     input logic [4:0] rd, input logic mr, input logic ma, input logic db, input logic bj);
    ID_RS1_ADDR = rs1; ID_RS2_ADDR = rs2; ID_RS1_USED = u1; ID_RS2_USED = u2;
    EX_RD_ADDR = rd; EX_MEM_READ = mr; MEM_ACCESS = ma; DMEM_BUSY = db; BJ_SIG = bj;
  endtask

  task automatic step(input string tag, input logic [4:0] e);
    sb_item_t it;
    sb.push_back('{tag, e});
    @(negedge CLK);
    it = sb.pop_front();
    chk(it.tag, 32'(obs), 32'(it.exp));
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    drv(5, 0, 1, 0, 5, 1, 1, 1, 1);
    step("in_reset", 5'b00000);
    chk("rst_lu_cnt", LU_STALL_CNT, 0);
    chk("rst_mem_cnt", MEM_STALL_CNT, 0);
    chk("rst_state", 32'(dut.state), 32'(HZ_RUN));
    RESET = 1'b0;
    idle();
    step("idle", 5'b00000);
    drv(5, 0, 1, 0, 5, 1, 0, 0, 0);
    step("lu_hit", 5'b01100);
    step("lu_bubble", 5'b00000);
    idle();
    step("lu_after", 5'b00000);
    chk("lu_cnt_1", LU_STALL_CNT, PERF ? 32'd1 : 32'd0);
    drv(0, 0, 1, 0, 0, 1, 0, 0, 0);
    step("rd_zero", 5'b00000);
    drv(0, 7, 0, 0, 7, 1, 0, 0, 0);
    step("rs2_unused", 5'b00000);
    drv(0, 7, 0, 1, 7, 1, 0, 0, 0);
    step("rs2_hit", 5'b01100);
    step("rs2_bubble", 5'b00000);
    drv(3, 0, 1, 0, 3, 1, 0, 0, 0);
    step("b2b_hit1", 5'b01100);
    step("b2b_bub1", 5'b00000);
    drv(0, 9, 0, 1, 9, 1, 0, 0, 0);
    step("b2b_hit2", 5'b01100);
    step("b2b_bub2", 5'b00000);
    drv(6, 0, 1, 0, 6, 1, 0, 0, 1);
    step("bj_prio", 5'b10000);
    drv(6, 0, 1, 0, 6, 1, 0, 0, 0);
    step("bj_state_run", 5'b01100);
    step("bj_bubble", 5'b00000);
    idle();
    step("idle2", 5'b00000);
    drv(6, 0, 1, 0, 6, 1, 1, 1, 1);
    step("frz1", 5'b00110);
    step("frz2", 5'b00110);
    step("frz3", 5'b00110);
    drv(6, 0, 1, 0, 6, 1, 1, 0, 1);
    step("frz_bj_free", 5'b10000);
    drv(6, 0, 1, 0, 6, 1, 0, 0, 0);
    step("frz_lu_after", 5'b01100);
    step("frz_bubble", 5'b00000);
    idle();
    step("idle3", 5'b00000);
    chk("lu_cnt_6", LU_STALL_CNT, PERF ? 32'd6 : 32'd0);
    chk("mem_cnt_3", MEM_STALL_CNT, PERF ? 32'd3 : 32'd0);
    drv(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step("wd1", 5'b00110);
    step("wd2", 5'b00110);
    step("wd3", 5'b00110);
    step("wd4", 5'b00110);
    step("wd5", 5'b00111);
    step("wd6", 5'b00111);
    chk("wd_sat_cnt", 32'(dut.wait_cnt), 32'd4);
    idle();
    step("wd_sticky1", 5'b00001);
    step("wd_sticky2", 5'b00001);
    chk("wd_cnt_clr", 32'(dut.wait_cnt), 32'd0);
    chk("mem_cnt_9", MEM_STALL_CNT, PERF ? 32'd9 : 32'd0);
    drv(4, 0, 1, 0, 4, 1, 1, 1, 1);
    step("mw1", 5'b00111);
    step("mw2", 5'b00111);
    chk("mw_cnt", 32'(dut.wait_cnt), 32'd2);
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_outs", 32'(obs), 32'd0);
    chk("arst_state", 32'(dut.state), 32'(HZ_RUN));
    chk("arst_wait", 32'(dut.wait_cnt), 32'd0);
    chk("arst_lu_cnt", LU_STALL_CNT, 0);
    chk("arst_mem_cnt", MEM_STALL_CNT, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    idle();
    step("post_rst", 5'b00000);
    drv(8, 0, 1, 0, 8, 1, 0, 0, 0);
    step("post_rst_lu", 5'b01100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
